// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: filtered clock/data, 11-bit frame checker, E0/F0 prefix
// decoder and a show-ahead event FIFO with error accounting.
module ps2_keyboard_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int FIFO_DEPTH     = 8,
   parameter int LEVEL_W        = 4
) (
   input  logic               CLOCK_50,
   input  logic               reset,
   input  logic               PS2_CLK,
   input  logic               PS2_DAT,
   input  logic               event_rd,
   input  logic               clear_errors,
   output logic               event_valid,
   output logic [7:0]         event_code,
   output logic               event_extended,
   output logic               event_released,
   output logic [LEVEL_W-1:0] fifo_level,
   output logic               overflow,
   output logic [7:0]         frame_error_count,
   output logic               rx_busy
);

   localparam int FCNT_W = $clog2(FILTER_LEN + 1);
   localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DATA   = 2'd1;
   localparam logic [1:0] PARITY = 2'd2;
   localparam logic [1:0] STOP   = 2'd3;

   logic              r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
   logic              r_clk_f, r_dat_f, r_clk_fd;
   logic [FCNT_W-1:0] r_clk_cnt, r_dat_cnt;

   logic [1:0]        r_state;
   logic [2:0]        r_bitcnt;
   logic [7:0]        r_shift;
   logic              r_parity;
   logic [TO_W-1:0]   r_to_cnt;
   logic              r_byte_ok_p1;
   logic [7:0]        r_byte_p1;
   logic              r_ext, r_rel;

   logic [9:0]        r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wptr, r_rptr;
   logic [LEVEL_W-1:0] r_level;
   logic              r_overflow;
   logic [7:0]        r_err_cnt;

   logic              w_fall, w_timeout, w_stop_ok, w_byte_done, w_frame_err;
   logic              w_is_ext, w_is_rel, w_is_ovr, w_dec_err, w_push, w_err;
   logic              w_valid, w_full, w_pop, w_wr, w_drop;
   logic [9:0]        w_head;

   // Synchronisers and debounce: a level changes only after FILTER_LEN differing samples
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         r_clk_s1  <= 1'b1;
         r_clk_s2  <= 1'b1;
         r_dat_s1  <= 1'b1;
         r_dat_s2  <= 1'b1;
         r_clk_f   <= 1'b1;
         r_dat_f   <= 1'b1;
         r_clk_fd  <= 1'b1;
         r_clk_cnt <= '0;
         r_dat_cnt <= '0;
      end else begin
         r_clk_s1 <= PS2_CLK;
         r_clk_s2 <= r_clk_s1;
         r_dat_s1 <= PS2_DAT;
         r_dat_s2 <= r_dat_s1;
         r_clk_fd <= r_clk_f;
         if (r_clk_s2 == r_clk_f) begin
            r_clk_cnt <= '0;
         end else if (r_clk_cnt == FCNT_W'(FILTER_LEN - 1)) begin
            r_clk_f   <= r_clk_s2;
            r_clk_cnt <= '0;
         end else begin
            r_clk_cnt <= r_clk_cnt + FCNT_W'(1);
         end
         if (r_dat_s2 == r_dat_f) begin
            r_dat_cnt <= '0;
         end else if (r_dat_cnt == FCNT_W'(FILTER_LEN - 1)) begin
            r_dat_f   <= r_dat_s2;
            r_dat_cnt <= '0;
         end else begin
            r_dat_cnt <= r_dat_cnt + FCNT_W'(1);
         end
      end
   end

   assign w_fall      = r_clk_fd & ~r_clk_f;
   assign w_timeout   = (r_state != IDLE) && !w_fall && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
   assign w_stop_ok   = r_dat_f & (^{r_shift, r_parity});
   assign w_byte_done = (r_state == STOP) && w_fall && w_stop_ok;
   assign w_frame_err = w_timeout | ((r_state == STOP) && w_fall && !w_stop_ok);

   // Frame FSM
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_bitcnt     <= '0;
         r_to_cnt     <= '0;
         r_byte_ok_p1 <= 1'b0;
      end else begin
         r_byte_ok_p1 <= w_byte_done;
         if (r_state == IDLE || w_fall) r_to_cnt <= '0;
         else                           r_to_cnt <= r_to_cnt + TO_W'(1);
         if (w_timeout) begin
            r_state <= IDLE;
         end else begin
            case (r_state)
               IDLE: if (w_fall && !r_dat_f) begin
                  r_state  <= DATA;
                  r_bitcnt <= '0;
               end
               DATA: if (w_fall) begin
                  r_bitcnt <= r_bitcnt + 3'd1;
                  if (r_bitcnt == 3'd7) r_state <= PARITY;
               end
               PARITY: if (w_fall) r_state <= STOP;
               STOP:   if (w_fall) r_state <= IDLE;
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (r_state == DATA && w_fall)   r_shift   <= {r_dat_f, r_shift[7:1]};
      if (r_state == PARITY && w_fall) r_parity  <= r_dat_f;
      if (w_byte_done)                 r_byte_p1 <= r_shift;
   end

   assign w_is_ext  = (r_byte_p1 == 8'hE0);
   assign w_is_rel  = (r_byte_p1 == 8'hF0);
   assign w_is_ovr  = (r_byte_p1 == 8'h00) || (r_byte_p1 == 8'hFF);
   assign w_dec_err = r_byte_ok_p1 & w_is_ovr;
   assign w_push    = r_byte_ok_p1 & ~w_is_ext & ~w_is_rel & ~w_is_ovr;
   assign w_err     = w_frame_err | w_dec_err;

   // Prefix decoder
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         r_ext <= 1'b0;
         r_rel <= 1'b0;
      end else if (w_err || w_push) begin
         r_ext <= 1'b0;
         r_rel <= 1'b0;
      end else if (r_byte_ok_p1 && w_is_ext) begin
         r_ext <= 1'b1;
      end else if (r_byte_ok_p1 && w_is_rel) begin
         r_rel <= 1'b1;
      end
   end

   assign w_valid = (r_level != '0);
   assign w_full  = (r_level == LEVEL_W'(FIFO_DEPTH));
   assign w_pop   = event_rd & w_valid;
   assign w_wr    = w_push & (~w_full | w_pop);
   assign w_drop  = w_push & w_full & ~w_pop;
   assign w_head  = r_mem[r_rptr];

   // Event FIFO and error accounting; a clear loses to an event in the same cycle
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
         r_err_cnt  <= '0;
      end else begin
         if (w_wr)  r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
         case ({w_wr, w_pop})
            2'b10:   r_level <= r_level + LEVEL_W'(1);
            2'b01:   r_level <= r_level - LEVEL_W'(1);
            default: r_level <= r_level;
         endcase
         if (clear_errors)  r_overflow <= w_drop;
         else if (w_drop)   r_overflow <= 1'b1;
         if (clear_errors)  r_err_cnt <= {7'd0, w_err};
         else if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (w_wr) r_mem[r_wptr] <= {r_ext, r_rel, r_byte_p1};
   end

   assign event_valid       = w_valid;
   assign event_code        = w_valid ? w_head[7:0] : 8'h00;
   assign event_extended    = w_valid & w_head[9];
   assign event_released    = w_valid & w_head[8];
   assign fifo_level        = r_level;
   assign overflow          = r_overflow;
   assign frame_error_count = r_err_cnt;
   assign rx_busy           = (r_state != IDLE);

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
- Receive-only PS/2 keyboard front end. Filters PS2_CLK, deserialises 11-bit frames and checks start, parity and stop bits.
- Decodes the E0 (extended) and F0 (break) prefixes into single key events and buffers them in a parametrised FIFO for game logic.
- Successor to the existing PS/2 transceiver's receive path. Adds glitch filtering, a frame timeout, error accounting, prefix decoding and event buffering.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronised samples needed before PS2_CLK/PS2_DAT change their filtered level.
- TIMEOUT_CYCLES, 100000: CLOCK_50 cycles without a filtered falling edge mid-frame before the frame is aborted (2 ms).
- FIFO_DEPTH, 8: event FIFO entries. Must be a power of 2, at least 2.
- LEVEL_W, 4: width of fifo_level. Must satisfy 2^LEVEL_W > FIFO_DEPTH.

Ports:
- CLOCK_50, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset.
- PS2_CLK, input, 1: raw PS/2 clock.
- PS2_DAT, input, 1: raw PS/2 data.
- event_rd, input, 1: pop head event. Ignored when FIFO is empty.
- clear_errors, input, 1: synchronous clear of overflow and frame_error_count.
- event_valid, output, 1: FIFO non-empty.
- event_code, output, 8: head scan code (show-ahead).
- event_extended, output, 1: head event was E0-prefixed.
- event_released, output, 1: head event was F0-prefixed (key release).
- fifo_level, output, LEVEL_W: number of entries in the FIFO.
- overflow, output, 1: sticky; an event was dropped because the FIFO was full.
- frame_error_count, output, 8: saturating count of rejected frames.
- rx_busy, output, 1: receive FSM is not in IDLE.

Behaviour:
- Reset (asserted low, asynchronous):
  - FSM goes to IDLE; FIFO is emptied; prefix flags are cleared.
  - Outputs: event_valid=0, event_code=0, event_extended=0, event_released=0, fifo_level=0, overflow=0, frame_error_count=0, rx_busy=0.
  - Filter state resets to 1 (bus idle high).
  - A frame in progress at reset is discarded and is not counted as an error.
- Input conditioning:
  - PS2_CLK and PS2_DAT each pass through a 2-flop synchroniser, then a FILTER_LEN-sample majority-free debounce.
  - A filtered falling edge of the clock is a 1-cycle strobe fall.
  - Data is sampled as the filtered PS2_DAT level in the fall cycle.
- Receive FSM (states IDLE, DATA, PARITY, STOP):
  - IDLE: on fall with data=0, go to DATA with bit counter=0. Data=1 on fall is ignored.
  - DATA: shift data in LSB-first on each fall. After the 8th bit, go to PARITY.
  - PARITY: capture the bit and go to STOP.
  - STOP: on fall, check stop=1 and odd parity over data+parity. Pass → raise byte_ok strobe. Fail → error. Return to IDLE in both cases.
- Timeout:
  - Counter clears on every fall and counts while the FSM is not in IDLE.
  - Reaching TIMEOUT_CYCLES → FSM returns to IDLE, error is raised, partial byte is discarded.
- Error handling:
  - Every error increments frame_error_count, saturating at 255, and clears both prefix flags.
- Decoder (acts on byte_ok, registered one cycle):
  - 0xE0 → ext flag=1.
  - 0xF0 → rel flag=1.
  - 0x00 or 0xFF (keyboard overrun) → discarded, flags cleared, counted as an error.
  - Any other byte → push {ext, rel, code} and clear both flags.
  - 0xE1 and all remaining bytes are pushed as plain codes.
- Latency:
  - Let S be the fall cycle that accepts the stop bit.
  - The byte is decoded in S+1; event_valid and the event fields are visible in S+2 (FIFO previously empty).
- FIFO:
  - Show-ahead: event_* always reflect the head entry while event_valid=1.
  - A pop on event_rd takes effect at the next edge.
  - Push when full without a same-cycle pop → new event dropped, overflow=1.
  - Push and pop in the same cycle when full → both succeed; level unchanged; no overflow.
  - Push and pop in the same cycle when empty → pop ignored; level becomes 1.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- clear_errors:
  - Clears overflow and frame_error_count on the next edge.
  - If an error or overflow occurs in the same cycle, the clear applies first, then the new event, giving count=1 or overflow=1.
- rx_busy=1 in DATA, PARITY and STOP.

Test Plan:
- Send frame 0x1C (parity bit 0, valid) → one event: code=0x1C, extended=0, released=0, valid at S+2; fifo_level=1. Pulse event_rd → event_valid=0, fifo_level=0.
- Send F0,1C then E0,74 then E0,F0,74 → three events: {1C,ext0,rel1}, {74,ext1,rel0}, {74,ext1,rel1}; no prefix byte appears as an event.
- Send 0x1C with parity bit 1 → no event, frame_error_count=1. Then send E0 followed by a bad-stop frame, then 0x74 → event {74,ext0,rel0}, count=2.
- Send start bit plus 4 data bits, then hold PS2_CLK high for TIMEOUT_CYCLES+10 → rx_busy falls, count increments. A following valid 0x29 frame is received correctly.
- FIFO_DEPTH=4: send 5 makes 0x15,0x1D,0x24,0x2D,0x2C without reading → level=4, overflow=1, head=0x15, 0x2C lost. Pop on the same cycle as a 6th push → level stays 4. Pulse clear_errors → overflow=0.
- Inject 2-cycle low glitches on PS2_CLK (FILTER_LEN=8) during an idle bus → no state change. Assert reset mid-frame → all outputs zero, count=0. The next full frame decodes normally.
